seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Monitor-side receiver for the multiplexed 7-segment display bus (seg/dp/line) driven by the stopwatch display scanner. Samples each scanned digit once it is stable, decodes the segment pattern back to a 4-bit hex value, and assembles four digits into a frame with a one-cycle valid strobe. Used for on-board self-test and for feeding the displayed time to downstream logic.

## Interface
- SETTLE, 16: consecutive stable cycles of synced line+seg required before a digit is sampled (2..255)
- TIMEOUT, 2_097_152: cycles with no line change before the bus is declared stale (22-bit counter)
- clk0  in  1  system clock, same domain as the scanner
- reset_sw  in  1  reset; asynchronous, active-high
- seg  in  7  segment pattern, bit6=a … bit0=g, active-high
- dp  in  1  decimal point for the currently selected digit
- line  in  4  one-hot digit select; bit n selects digit n (0 = rightmost, 0.1 s)
- value  out  16  {d3,d2,d1,d0} of the last complete frame
- dp_mask  out  4  dp bit per digit of the last complete frame
- frame_valid  out  1  one-cycle pulse when value/dp_mask update
- pattern_err  out  1  one-cycle pulse on sample of an undecodable pattern
- line_err  out  1  one-cycle pulse when synced line changes to a non-one-hot value
- stale  out  1  level; bus has not scanned for TIMEOUT cycles

## Operation
- seg, dp, line pass through 2-flop synchronizers; all logic below uses synced values.
- Decode table (seg→hex): 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110010→7, 1111111→8, 1111011→9, 1110111→A, 0011111→b, 1001110→C, 0111101→d, 1001111→E, 1000111→F. Any other pattern, including 0000000, is invalid.
- FSM states:
  - IDLE: wait for a change of synced line to a one-hot value → SETTLE.
  - SETTLE: settle counter increments each cycle line and seg are unchanged; any change of seg restarts it at 0; change of line to one-hot restarts it at 0 for the new digit; change to non-one-hot → line_err, IDLE. Counter reaching SETTLE → sample, → HOLD.
  - HOLD: sample taken; wait for line change (same rules as IDLE, one-hot → SETTLE, else line_err → IDLE).
- Sample: valid pattern → write digit slot n and dp bit n into staging registers, set mask bit n. Invalid pattern → pattern_err pulse, clear mask (frame discarded), slot not written.
- A digit sampled twice before frame completes overwrites its slot.
- mask==4'b1111 → copy staging to value/dp_mask, pulse frame_valid, clear mask.
- Timeout counter clears on every synced line change and saturates at TIMEOUT; reaching TIMEOUT sets stale, clears mask, FSM → IDLE. stale clears on next line change.

## Timing
- Reset values: value=0, dp_mask=0, frame_valid=0, pattern_err=0, line_err=0, stale=0; mask, counters cleared, FSM IDLE, synchronizers 0.
- Raw line edge → synced: 2 cycles. Sample registered SETTLE cycles after the synced change if stable; frame_valid asserted the cycle after the fourth sample is registered; value updates in the same cycle as frame_valid.
- line_err/pattern_err asserted the cycle after the offending synced value/sample.
- Line change and timeout in the same cycle: line change wins, stale not set.
- Sample and line change in the same cycle: line change wins, no sample.
- reset_sw mid-frame: immediate clear of all state; staged digits lost, no frame_valid.
- Only the final frame_valid edge is required; frames may be missed while stale or after errors.

## Test plan
- Scan digits 0..3 with patterns for 7,3,0,1 (dp on digit1), 64 cycles each → one frame_valid, value=16'h1037, dp_mask=4'b0010.
- Toggle seg every 8 cycles while line=0001 for 100 cycles, SETTLE=16 → no sample; stabilize → sample after exactly 16 stable cycles.
- Digit2 pattern 0000000 in otherwise valid scan → pattern_err pulse, no frame_valid that pass; next clean scan → frame_valid.
- line driven 0011 → line_err pulse, FSM IDLE, mask cleared; value unchanged.
- Freeze line for TIMEOUT cycles → stale=1 at cycle TIMEOUT; resume scanning → stale=0 at first change, frame_valid after full scan.
- Assert reset_sw after 3 digits sampled → all outputs 0; subsequent digit3 alone produces no frame_valid.

Source files
------------

// File: rtl/seg_scan_if.sv
// Multiplexed 7-segment scan bus as seen by the monitor: the scanner side
// (seg/dp/line) plus the decoded frame and status outputs.
interface seg_scan_if;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  line;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        frame_valid;
  logic        pattern_err;
  logic        line_err;
  logic        stale;

  modport master (
    output seg, dp, line,
    input  value, dp_mask, frame_valid, pattern_err, line_err, stale
  );

  modport slave (
    input  seg, dp, line,
    output value, dp_mask, frame_valid, pattern_err, line_err, stale
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Monitor-side receiver for the scanned 7-segment bus: samples each settled
// digit, decodes it to hex and assembles four digits into a frame.
module seg_scan_decoder #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 2_097_152
) (
  input  logic      clk0,
  input  logic      reset_sw,
  seg_scan_if.slave bus
);

  localparam int SW = $clog2(SETTLE);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [6:0]      seg_p0, seg_p1, seg_p2;
  logic            dp_p0, dp_p1;
  logic [3:0]      line_p0, line_p1, line_p2;

  state_t          state, state_n;
  logic [SW-1:0]   cnt, cnt_n;
  logic [1:0]      dig, dig_n;
  logic [TW-1:0]   tcnt;

  logic            line_chg, seg_chg, line_ok;
  logic            timeout_hit, do_sample, err_line;
  logic [4:0]      dec;

  logic [3:0][3:0] stage;
  logic [3:0]      stage_dp;
  logic [3:0]      mask;

  logic [15:0]     value_r;
  logic [3:0]      dp_mask_r;
  logic            frame_valid_r, pattern_err_r, line_err_r, stale_r;

  // {valid, hex}; anything outside the sixteen glyphs is reported invalid
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1111110: decode_seg = {1'b1, 4'h0};
      7'b0110000: decode_seg = {1'b1, 4'h1};
      7'b1101101: decode_seg = {1'b1, 4'h2};
      7'b1111001: decode_seg = {1'b1, 4'h3};
      7'b0110011: decode_seg = {1'b1, 4'h4};
      7'b1011011: decode_seg = {1'b1, 4'h5};
      7'b1011111: decode_seg = {1'b1, 4'h6};
      7'b1110010: decode_seg = {1'b1, 4'h7};
      7'b1111111: decode_seg = {1'b1, 4'h8};
      7'b1111011: decode_seg = {1'b1, 4'h9};
      7'b1110111: decode_seg = {1'b1, 4'hA};
      7'b0011111: decode_seg = {1'b1, 4'hB};
      7'b1001110: decode_seg = {1'b1, 4'hC};
      7'b0111101: decode_seg = {1'b1, 4'hD};
      7'b1001111: decode_seg = {1'b1, 4'hE};
      7'b1000111: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = 5'b0_0000;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [3:0] l);
    is_one_hot = (l != 4'b0000) && ((l & (l - 4'd1)) == 4'b0000);
  endfunction

  // Only meaningful for one-hot inputs
  function automatic logic [1:0] one_hot_index(input logic [3:0] l);
    one_hot_index = {l[3] | l[2], l[3] | l[1]};
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synced value
  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      seg_p0  <= '0;
      seg_p1  <= '0;
      seg_p2  <= '0;
      dp_p0   <= 1'b0;
      dp_p1   <= 1'b0;
      line_p0 <= '0;
      line_p1 <= '0;
      line_p2 <= '0;
    end else begin
      seg_p0  <= bus.seg;
      seg_p1  <= seg_p0;
      seg_p2  <= seg_p1;
      dp_p0   <= bus.dp;
      dp_p1   <= dp_p0;
      line_p0 <= bus.line;
      line_p1 <= line_p0;
      line_p2 <= line_p1;
    end
  end

  assign line_chg    = (line_p1 != line_p2);
  assign seg_chg     = (seg_p1 != seg_p2);
  assign line_ok     = is_one_hot(line_p1);
  assign dec         = decode_seg(seg_p1);
  assign timeout_hit = !line_chg && (tcnt == TO_LAST);

  // A line change always beats a timeout landing in the same cycle
  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      tcnt    <= '0;
      stale_r <= 1'b0;
    end else if (line_chg) begin
      tcnt    <= '0;
      stale_r <= 1'b0;
    end else if (tcnt != TO_MAX) begin
      tcnt    <= tcnt + TW'(1);
      if (timeout_hit) stale_r <= 1'b1;
    end
  end

  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dig   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dig   <= dig_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dig_n     = dig;
    do_sample = 1'b0;
    err_line  = 1'b0;
    if (line_chg) begin
      if (line_ok) begin
        state_n = ST_SETTLE;
        cnt_n   = '0;
        dig_n   = one_hot_index(line_p1);
      end else begin
        state_n  = ST_IDLE;
        err_line = 1'b1;
      end
    end else if (timeout_hit) begin
      state_n = ST_IDLE;
    end else if (state == ST_SETTLE) begin
      if (seg_chg) begin
        cnt_n = '0;
      end else if (cnt == SETTLE_LAST) begin
        do_sample = 1'b1;
        state_n   = ST_HOLD;
      end else begin
        cnt_n = cnt + SW'(1);
      end
    end
  end

  // Frame assembly: a full mask is published before any clear is considered
  always_ff @(posedge clk0 or posedge reset_sw) begin
    if (reset_sw) begin
      stage         <= '0;
      stage_dp      <= '0;
      mask          <= '0;
      value_r       <= '0;
      dp_mask_r     <= '0;
      frame_valid_r <= 1'b0;
      pattern_err_r <= 1'b0;
      line_err_r    <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      pattern_err_r <= 1'b0;
      line_err_r    <= err_line;
      if (mask == 4'b1111) begin
        value_r       <= stage;
        dp_mask_r     <= stage_dp;
        frame_valid_r <= 1'b1;
        mask          <= '0;
      end else if (err_line || timeout_hit) begin
        mask <= '0;
      end else if (do_sample) begin
        if (dec[4]) begin
          stage[dig]    <= dec[3:0];
          stage_dp[dig] <= dp_p1;
          mask[dig]     <= 1'b1;
        end else begin
          pattern_err_r <= 1'b1;
          mask          <= '0;
        end
      end
    end
  end

  assign bus.value       = value_r;
  assign bus.dp_mask     = dp_mask_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.pattern_err = pattern_err_r;
  assign bus.line_err    = line_err_r;
  assign bus.stale       = stale_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan sequences checked every cycle
// against a behavioural model of the scan bus receiver.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 400;
  localparam int DWELL   = 64;
  localparam logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic clk0 = 1'b0;
  logic reset_sw = 1'b1;
  logic cmp_en = 1'b0;

  seg_scan_if bus();

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk0     (clk0),
    .reset_sw (reset_sw),
    .bus      (bus)
  );

  always #5 clk0 = ~clk0;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int pe_cnt = 0;
  int le_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode_model(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (PAT[i] == s) return i;
    return -1;
  endfunction

  // Model: synced = raw two edges back; a digit is taken when the synced
  // line/seg pair has been unchanged for SETTLE comparisons since arming.
  logic [3:0]  m_l0 = '0, m_l1 = '0, m_pl = '0;
  logic [6:0]  m_s0 = '0, m_s1 = '0, m_ps = '0;
  logic        m_d0 = 1'b0, m_d1 = 1'b0;
  int          m_run = 0, m_nochg = 0, m_dig = 0;
  bit          m_armed = 1'b0;
  int          m_digit [4];
  bit          m_dpb [4];
  bit          m_have [4];
  logic [15:0] exp_value = '0;
  logic [3:0]  exp_dpm = '0;
  logic        exp_fv = 1'b0, exp_pe = 1'b0, exp_le = 1'b0, exp_stale = 1'b0;

  always @(posedge clk0) begin : model
    logic [3:0] sl;
    logic [6:0] ss;
    logic       sd;
    bit         lchg, schg, full;
    int         d;
    if (reset_sw) begin
      m_l0 = '0; m_l1 = '0; m_pl = '0;
      m_s0 = '0; m_s1 = '0; m_ps = '0;
      m_d0 = 1'b0; m_d1 = 1'b0;
      m_run = 0; m_nochg = 0; m_armed = 1'b0; m_dig = 0;
      for (int i = 0; i < 4; i++) begin m_digit[i] = 0; m_dpb[i] = 1'b0; m_have[i] = 1'b0; end
      exp_value = '0; exp_dpm = '0;
      exp_fv = 1'b0; exp_pe = 1'b0; exp_le = 1'b0; exp_stale = 1'b0;
    end else begin
      sl = m_l1; ss = m_s1; sd = m_d1;
      m_l1 = m_l0; m_l0 = bus.line;
      m_s1 = m_s0; m_s0 = bus.seg;
      m_d1 = m_d0; m_d0 = bus.dp;
      lchg = (sl != m_pl);
      schg = (ss != m_ps);
      m_pl = sl; m_ps = ss;
      if (lchg) m_nochg = 0;
      else if (m_nochg <= TIMEOUT) m_nochg++;
      if (lchg || schg) m_run = 0;
      else if (m_run < 100000) m_run++;
      full = m_have[0] && m_have[1] && m_have[2] && m_have[3];
      exp_fv = 1'b0; exp_pe = 1'b0; exp_le = 1'b0;
      if (full) begin
        for (int i = 0; i < 4; i++) begin
          exp_value[i*4 +: 4] = 4'(m_digit[i]);
          exp_dpm[i] = m_dpb[i];
          m_have[i] = 1'b0;
        end
        exp_fv = 1'b1;
      end
      if (lchg) begin
        exp_stale = 1'b0;
        if ($countones(sl) == 1) begin
          m_armed = 1'b1;
          for (int i = 0; i < 4; i++) if (sl[i]) m_dig = i;
        end else begin
          exp_le = 1'b1;
          m_armed = 1'b0;
          for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
        end
      end else if (m_nochg == TIMEOUT) begin
        exp_stale = 1'b1;
        m_armed = 1'b0;
        for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
      end else if (m_armed && m_run == SETTLE) begin
        m_armed = 1'b0;
        d = decode_model(ss);
        if (d >= 0) begin
          m_digit[m_dig] = d;
          m_dpb[m_dig] = sd;
          m_have[m_dig] = 1'b1;
        end else begin
          exp_pe = 1'b1;
          for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk0) begin
    if (cmp_en) begin
      check("value",       32'(bus.value),       32'(exp_value));
      check("dp_mask",     32'(bus.dp_mask),     32'(exp_dpm));
      check("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
      check("pattern_err", 32'(bus.pattern_err), 32'(exp_pe));
      check("line_err",    32'(bus.line_err),    32'(exp_le));
      check("stale",       32'(bus.stale),       32'(exp_stale));
    end
    if (bus.frame_valid === 1'b1) fv_cnt++;
    if (bus.pattern_err === 1'b1) pe_cnt++;
    if (bus.line_err === 1'b1)    le_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk0);
      #1;
    end
  endtask

  task automatic show(input logic [3:0] l, input logic [6:0] s, input logic d, input int n);
    bus.line = l;
    bus.seg  = s;
    bus.dp   = d;
    tick(n);
  endtask

  task automatic dig(input int n, input logic [6:0] s, input logic d);
    show(4'(1 << n), s, d, DWELL);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"},   32'(bus.value),       32'h0);
    check({tag, "_dpmask"},  32'(bus.dp_mask),     32'h0);
    check({tag, "_fv"},      32'(bus.frame_valid), 32'h0);
    check({tag, "_pe"},      32'(bus.pattern_err), 32'h0);
    check({tag, "_le"},      32'(bus.line_err),    32'h0);
    check({tag, "_stale"},   32'(bus.stale),       32'h0);
  endtask

  initial begin
    bus.line = '0;
    bus.seg  = '0;
    bus.dp   = 1'b0;
    reset_sw = 1'b1;
    tick(3);
    cmp_en = 1'b1;
    check_all_zero("reset");
    reset_sw = 1'b0;
    tick(2);

    // Basic scan 7,3,0,1 with dp on digit1
    dig(0, PAT[7], 1'b0);
    dig(1, PAT[3], 1'b1);
    dig(2, PAT[0], 1'b0);
    dig(3, PAT[1], 1'b0);
    check("scan1_value", 32'(bus.value), 32'h1037);
    check("scan1_dpmask", 32'(bus.dp_mask), 32'h2);
    check("scan1_frames", 32'(fv_cnt), 32'd1);

    // Unsettled segments never sample; an invalid glyph held still samples after 16 stable cycles
    for (int i = 0; i < 13; i++) show(4'b0001, (i % 2) ? PAT[8] : PAT[7], 1'b0, 8);
    show(4'b0001, 7'b0000000, 1'b0, 18);
    check("settle_pe_early", 32'(bus.pattern_err), 32'h0);
    tick(1);
    check("settle_pe_on", 32'(bus.pattern_err), 32'h1);
    tick(1);
    check("settle_pe_off", 32'(bus.pattern_err), 32'h0);
    tick(20);
    check("settle_pe_count", 32'(pe_cnt), 32'd1);

    // Invalid digit discards the frame; the following clean scan completes
    dig(3, PAT[9], 1'b1);
    dig(0, PAT[5], 1'b0);
    dig(1, PAT[2], 1'b0);
    dig(2, 7'b0000000, 1'b0);
    check("bad_pe_count", 32'(pe_cnt), 32'd2);
    check("bad_frames", 32'(fv_cnt), 32'd1);
    dig(0, PAT[10], 1'b1);
    dig(1, PAT[11], 1'b0);
    dig(2, PAT[12], 1'b0);
    dig(3, PAT[13], 1'b1);
    check("clean_value", 32'(bus.value), 32'hDCBA);
    check("clean_dpmask", 32'(bus.dp_mask), 32'h9);
    check("clean_frames", 32'(fv_cnt), 32'd2);

    // Non-one-hot line aborts the partial frame
    dig(0, PAT[1], 1'b0);
    dig(1, PAT[2], 1'b0);
    show(4'b0011, PAT[3], 1'b0, 2);
    check("lerr_early", 32'(bus.line_err), 32'h0);
    tick(1);
    check("lerr_on", 32'(bus.line_err), 32'h1);
    tick(DWELL - 3);
    dig(2, PAT[3], 1'b0);
    dig(3, PAT[4], 1'b0);
    check("lerr_count", 32'(le_cnt), 32'd1);
    check("lerr_frames", 32'(fv_cnt), 32'd2);
    check("lerr_value", 32'(bus.value), 32'hDCBA);

    // Frozen line goes stale after TIMEOUT cycles; scanning again clears it
    show(4'b0001, PAT[14], 1'b0, TIMEOUT + 2);
    check("stale_early", 32'(bus.stale), 32'h0);
    tick(1);
    check("stale_on", 32'(bus.stale), 32'h1);
    show(4'b0010, PAT[4], 1'b0, 2);
    check("stale_hold", 32'(bus.stale), 32'h1);
    tick(1);
    check("stale_off", 32'(bus.stale), 32'h0);
    tick(DWELL - 3);
    dig(2, PAT[5], 1'b0);
    dig(3, PAT[6], 1'b0);
    dig(0, PAT[14], 1'b0);
    check("resume_frames", 32'(fv_cnt), 32'd3);
    check("resume_value", 32'(bus.value), 32'h654E);
    check("resume_dpmask", 32'(bus.dp_mask), 32'h0);

    // Reset mid-frame loses the staged digits
    dig(1, PAT[8], 1'b0);
    dig(2, PAT[15], 1'b1);
    dig(0, PAT[0], 1'b0);
    reset_sw = 1'b1;
    bus.line = 4'b1000;
    bus.seg  = PAT[9];
    tick(2);
    check_all_zero("midreset");
    reset_sw = 1'b0;
    tick(2 * DWELL);
    check("midreset_frames", 32'(fv_cnt), 32'd3);
    check("midreset_value", 32'(bus.value), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
